// File: rtl/simd_bus_master.sv
// Initiator for the 8-bit pico parallel bus: one valid/ready command becomes one timed bus cycle.
// Latency: bus ops occupy SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, execute EXEC_CYC, then one IDLE cycle.
// Backpressure: cmd_ready is high only in IDLE, so at most one command is in flight.
module simd_bus_master #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int EXEC_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    output logic       bus_rd_n,
    output logic       bus_cd,
    output logic       bus_excute,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;

    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_EXEC = 2'b11;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] EXEC_LD  = 4'(EXEC_CYC - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic [1:0] op;
    logic       accept;

    assign accept = (state == S_IDLE) && cmd_ready && cmd_valid;

    // Every pin is registered; the value a phase needs is loaded on the edge that enters it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            op         <= 2'b00;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            bus_cs_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_rd_n   <= 1'b1;
            bus_cd     <= 1'b0;
            bus_excute <= 1'b0;
            bus_dout   <= 8'h00;
            bus_oe     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        op        <= cmd_op;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_EXEC) begin
                            state      <= S_EXEC;
                            cnt        <= EXEC_LD;
                            bus_excute <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            cnt      <= SETUP_LD;
                            bus_cs_n <= 1'b0;
                            bus_cd   <= (cmd_op == OP_ADDR);
                            if (cmd_op != OP_READ) begin
                                bus_oe   <= 1'b1;
                                bus_dout <= cmd_wdata;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= S_STROBE;
                        cnt   <= PULSE_LD;
                        if (op == OP_READ) bus_rd_n <= 1'b0;
                        else               bus_wr_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 4'd0) begin
                        state    <= S_HOLD;
                        cnt      <= HOLD_LD;
                        bus_wr_n <= 1'b1;
                        bus_rd_n <= 1'b1;
                        if (op == OP_READ) begin
                            rsp_rdata <= bus_din;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        state     <= S_IDLE;
                        bus_cs_n  <= 1'b1;
                        bus_oe    <= 1'b0;
                        bus_cd    <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        state      <= S_IDLE;
                        bus_excute <= 1'b0;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus_cs_n   <= 1'b1;
                    bus_wr_n   <= 1'b1;
                    bus_rd_n   <= 1'b1;
                    bus_cd     <= 1'b0;
                    bus_excute <= 1'b0;
                    bus_oe     <= 1'b0;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_bus_master.sv
// Bench for simd_bus_master: default-timing instance u0 plus a stretched-timing instance u1.
module tb_simd_bus_master;

    typedef struct packed {
        logic       cmd_ready;
        logic       busy;
        logic       cs_n;
        logic       wr_n;
        logic       rd_n;
        logic       cd;
        logic       excute;
        logic       oe;
        logic [7:0] dout;
        logic       rsp_valid;
        logic [7:0] rdata;
    } pins_t;

    localparam int S0 = 1, P0 = 2, H0 = 1, E0 = 4;
    localparam int S1 = 2, P1 = 3, H1 = 2, E1 = 3;
    localparam pins_t RST_PINS = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_din;

    logic       cmd_valid, cmd_ready, rsp_valid, busy;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata, rsp_rdata, bus_dout;
    logic       bus_cs_n, bus_wr_n, bus_rd_n, bus_cd, bus_excute, bus_oe;

    logic       c1_valid, c1_ready, r1_valid, busy1;
    logic [1:0] c1_op;
    logic [7:0] c1_wdata, r1_rdata, dout1;
    logic       cs1_n, wr1_n, rd1_n, cd1, ex1, oe1;

    pins_t obs0, obs1;
    assign obs0 = {cmd_ready, busy, bus_cs_n, bus_wr_n, bus_rd_n, bus_cd, bus_excute, bus_oe,
                   bus_dout, rsp_valid, rsp_rdata};
    assign obs1 = {c1_ready, busy1, cs1_n, wr1_n, rd1_n, cd1, ex1, oe1, dout1, r1_valid, r1_rdata};

    int checks = 0;
    int errors = 0;
    logic [7:0] m_dout, m_rdata;

    always #5 clk = ~clk;

    simd_bus_master #(.SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0), .EXEC_CYC(E0)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n), .bus_cd(bus_cd),
        .bus_excute(bus_excute), .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din));

    simd_bus_master #(.SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1), .EXEC_CYC(E1)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op),
        .cmd_wdata(c1_wdata), .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .busy(busy1),
        .bus_cs_n(cs1_n), .bus_wr_n(wr1_n), .bus_rd_n(rd1_n), .bus_cd(cd1),
        .bus_excute(ex1), .bus_dout(dout1), .bus_oe(oe1), .bus_din(bus_din));

    // Reference: expected pins k cycles after the accept edge (k = occupancy+1 is the IDLE cycle).
    function automatic pins_t exp_pins(input logic [1:0] op, input logic [7:0] wd, din, pd, pr,
                                       input int k, s, p, h, e);
        pins_t x;
        x = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pd, 1'b0, pr};
        if (op == 2'b11) begin
            if (k <= e) x.excute = 1'b1;
            else begin x.cmd_ready = 1'b1; x.busy = 1'b0; end
        end else begin
            if (op != 2'b10) x.dout = wd;
            if (op == 2'b10 && k > s + p) x.rdata = din;
            if (k <= s + p + h) begin
                x.cs_n      = 1'b0;
                x.cd        = (op == 2'b00);
                x.oe        = (op != 2'b10);
                x.wr_n      = !(op != 2'b10 && k > s && k <= s + p);
                x.rd_n      = !(op == 2'b10 && k > s && k <= s + p);
                x.rsp_valid = (op == 2'b10 && k == s + p + 1);
            end else begin
                x.cmd_ready = 1'b1;
                x.busy      = 1'b0;
            end
        end
        return x;
    endfunction

    // Called right after a negedge; returns just after the accept edge of u0.
    task automatic start0(input logic [1:0] op, input logic [7:0] wd, input bit hold, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=cmd_ready low exp=cmd_ready high within 50 cycles");
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wdata = 8'h00;
        c1_valid = 1'b0; c1_op = 2'b00; c1_wdata = 8'h00; bus_din = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (obs0 !== RST_PINS) begin errors++; $display("FAIL reset_u0 got=%h exp=%h", obs0, RST_PINS); end
        checks++;
        if (obs1 !== RST_PINS) begin errors++; $display("FAIL reset_u1 got=%h exp=%h", obs1, RST_PINS); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_release got=ready%b busy%b exp=ready1 busy0", cmd_ready, busy); end
        m_dout = 8'h00; m_rdata = 8'h00;
    endtask

    task automatic test_write_addr;
        bit ok; pins_t e;
        bus_din = 8'hEE;
        start0(2'b00, 8'h12, 1'b0, ok);
        if (!ok) return;
        for (int k = 1; k <= S0 + P0 + H0 + 1; k++) begin
            @(negedge clk);
            e = exp_pins(2'b00, 8'h12, bus_din, m_dout, m_rdata, k, S0, P0, H0, E0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL write_addr k=%0d got=%h exp=%h", k, obs0, e); end
        end
        m_dout = 8'h12;
    endtask

    task automatic test_read;
        bit ok; pins_t e; int pulses;
        pulses = 0;
        bus_din = 8'hA5;
        start0(2'b10, 8'h00, 1'b0, ok);
        if (!ok) return;
        for (int k = 1; k <= S0 + P0 + H0 + 1; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
            e = exp_pins(2'b10, 8'h00, 8'hA5, m_dout, m_rdata, k, S0, P0, H0, E0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL read k=%0d got=%h exp=%h", k, obs0, e); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL read_rsp_pulses got=%0d exp=1", pulses); end
        m_rdata = 8'hA5;
    endtask

    task automatic test_exec;
        bit ok; pins_t e;
        start0(2'b11, 8'h55, 1'b0, ok);
        if (!ok) return;
        for (int k = 1; k <= E0 + 1; k++) begin
            @(negedge clk);
            e = exp_pins(2'b11, 8'h55, bus_din, m_dout, m_rdata, k, S0, P0, H0, E0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL exec k=%0d got=%h exp=%h", k, obs0, e); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok; pins_t e; int l, gap, bad_cd;
        logic prev_cd, prev_cs;
        l = S0 + P0 + H0; gap = 0; bad_cd = 0;
        prev_cd = bus_cd; prev_cs = bus_cs_n;
        start0(2'b00, 8'h03, 1'b1, ok);
        if (!ok) return;
        cmd_op = 2'b01; cmd_wdata = 8'h7F;
        for (int k = 1; k <= 2 * (l + 1); k++) begin
            @(negedge clk);
            if (k == l + 2) cmd_valid = 1'b0;
            if (k <= l + 1) e = exp_pins(2'b00, 8'h03, bus_din, m_dout, m_rdata, k, S0, P0, H0, E0);
            else            e = exp_pins(2'b01, 8'h7F, bus_din, 8'h03, m_rdata, k - l - 1, S0, P0, H0, E0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, obs0, e); end
            if (k <= 2 * l + 1 && bus_cs_n === 1'b1) gap++;
            if (bus_cd !== prev_cd && bus_cs_n === 1'b0 && prev_cs === 1'b0) bad_cd++;
            prev_cd = bus_cd; prev_cs = bus_cs_n;
        end
        checks++;
        if (gap != 1) begin errors++; $display("FAIL b2b_cs_gap got=%0d exp=1", gap); end
        checks++;
        if (bad_cd != 0) begin errors++; $display("FAIL b2b_cd_under_cs got=%0d exp=0", bad_cd); end
        m_dout = 8'h7F;
    endtask

    task automatic test_random;
        bit ok; pins_t e; logic [1:0] op; logic [7:0] wd, din; int occ;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3)); wd = 8'($urandom); din = 8'($urandom);
            bus_din = din;
            start0(op, wd, 1'b0, ok);
            if (!ok) return;
            occ = (op == 2'b11) ? E0 : S0 + P0 + H0;
            for (int k = 1; k <= occ + 1; k++) begin
                @(negedge clk);
                e = exp_pins(op, wd, din, m_dout, m_rdata, k, S0, P0, H0, E0);
                checks++;
                if (obs0 !== e) begin errors++; $display("FAIL random n=%0d op=%0d k=%0d got=%h exp=%h", n, op, k, obs0, e); end
                checks++;
                if ((bus_wr_n === 1'b0 && bus_rd_n === 1'b0) || (bus_excute === 1'b1 && bus_cs_n === 1'b0))
                    begin errors++; $display("FAIL random_exclusive n=%0d got=wr%b rd%b ex%b cs%b exp=no overlap", n, bus_wr_n, bus_rd_n, bus_excute, bus_cs_n); end
            end
            if (op == 2'b00 || op == 2'b01) m_dout = wd;
            if (op == 2'b10) m_rdata = din;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        bus_din = 8'h5A;
        start0(2'b10, 8'h00, 1'b0, ok);
        if (!ok) return;
        repeat (S0 + 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs0 !== RST_PINS) begin errors++; $display("FAIL abort_pins got=%h exp=%h", obs0, RST_PINS); end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00)
                begin errors++; $display("FAIL abort_rsp k=%0d got=v%b d%h exp=v0 d00", k, rsp_valid, rsp_rdata); end
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        m_dout = 8'h00; m_rdata = 8'h00;
    endtask

    task automatic test_params;
        pins_t e; logic [1:0] op; logic [7:0] wd; logic [7:0] pd, pr; bit ok;
        pd = 8'h00; pr = 8'h00;
        for (int c = 0; c < 2; c++) begin
            op = (c == 0) ? 2'b01 : 2'b10;
            wd = (c == 0) ? 8'hC3 : 8'h00;
            bus_din = 8'h96;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (c1_ready === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL params_accept_timeout got=cmd_ready low exp=cmd_ready high within 50 cycles");
                return;
            end
            c1_valid = 1'b1; c1_op = op; c1_wdata = wd;
            @(posedge clk); #1;
            c1_valid = 1'b0;
            for (int k = 1; k <= S1 + P1 + H1 + 1; k++) begin
                @(negedge clk);
                e = exp_pins(op, wd, 8'h96, pd, pr, k, S1, P1, H1, E1);
                checks++;
                if (obs1 !== e) begin errors++; $display("FAIL params op=%0d k=%0d got=%h exp=%h", op, k, obs1, e); end
            end
            if (c == 0) pd = wd; else pr = 8'h96;
        end
    endtask

    initial begin
        test_reset;
        test_write_addr;
        test_read;
        test_exec;
        test_back_to_back;
        test_random;
        test_reset_abort;
        test_params;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_bus_master.md
Name: simd_bus_master

Overview:
Initiator side of the 8-bit pico parallel bus consumed by SIMD_CNN. The bus uses CS, WR, RD and CD (1=address, 0=data), plus a separate excute line.
- Converts single commands on a valid/ready interface into timed bus cycles: address write, data write, data read, execute pulse.
- Returns read data on a response pulse.
- Used on-FPGA to preload SIMD_CNN (weights/config) and fetch results without the pico.
- Drives bus pins through an external tristate (bus_oe).

Parameters:
SETUP_CYC, 1, cycles CS/CD/data valid before strobe asserts (1..15)
PULSE_CYC, 2, cycles WR or RD strobe held active (1..15)
HOLD_CYC, 1, cycles CS/CD/data held after strobe deasserts (1..15)
EXEC_CYC, 4, cycles excute held high for an execute command (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00=write addr, 01=write data, 10=read data, 11=execute
cmd_wdata  in  8  address/data byte for write ops (ignored otherwise)
rsp_valid  out  1  one-cycle pulse: rsp_rdata updated by a read
rsp_rdata  out  8  last read byte
busy  out  1  transaction in progress (inverse of cmd_ready when out of reset)
bus_cs_n  out  1  chip select, active-low
bus_wr_n  out  1  write strobe, active-low
bus_rd_n  out  1  read strobe, active-low
bus_cd  out  1  1=address phase, 0=data phase
bus_excute  out  1  execute, active-high
bus_dout  out  8  byte driven to bus
bus_oe  out  1  1=drive bus_dout onto bus
bus_din  in  8  byte sampled from bus

Behaviour:
Clock and reset:
- Single clock, clk.
- rst is synchronous and active-low; it is sampled only on the rising edge of clk.

Reset values (while rst=0 and the cycle after):
- bus_cs_n=1, bus_wr_n=1, bus_rd_n=1, bus_cd=0, bus_excute=0, bus_oe=0, bus_dout=0.
- rsp_valid=0, rsp_rdata=0, cmd_ready=0, busy=0, state=IDLE.

Reset mid-operation:
- Aborts immediately: all bus pins inactive the next cycle.
- The command is dropped and no rsp_valid is issued.

Command acceptance:
- cmd_ready=1 only in IDLE with rst=1.
- Accept occurs on a cycle with cmd_valid & cmd_ready; cmd_op and cmd_wdata are latched then.
- All outputs are registered.

FSM states: IDLE, SETUP, STROBE, HOLD, EXEC.

Bus ops (00/01/10), in order:
- SETUP (SETUP_CYC cycles, starting the cycle after accept):
  - cs_n=0; cd=1 for op 00, cd=0 for ops 01/10.
  - Writes: oe=1, dout=latched byte. Reads: oe=0.
- STROBE (PULSE_CYC cycles):
  - wr_n=0 for writes, rd_n=0 for reads; other signals unchanged.
  - Reads capture bus_din into rsp_rdata on the last STROBE cycle's clock edge.
- HOLD (HOLD_CYC cycles):
  - Strobes back to 1; cs_n, cd, oe and dout unchanged.
  - Reads: rsp_valid=1 in the first HOLD cycle only.
- Return to IDLE: cs_n=1, oe=0, cd=0; dout keeps its last value.

Execute op (11):
- EXEC lasts EXEC_CYC cycles with excute=1, cs_n=1, oe=0, all strobes inactive.
- Then IDLE.

Timing rules:
- Bus op occupancy = SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- Back-to-back commands always see at least one IDLE cycle with cs_n=1, because acceptance happens in IDLE.
- WR and RD are never active simultaneously.
- excute is never active while cs_n=0.
- rsp_rdata holds its value until the next read capture.

Counter:
- One 4-bit down-counter, loaded with N-1 on entering each phase.
- Phase ends when the counter reaches 0.

Test Plan:
- Write addr: defaults, op 00, wdata 0x12 accepted at cycle T.
  - cs_n=0, cd=1, oe=1, dout=0x12 during T+1..T+4.
  - wr_n=0 at T+2..T+3.
  - cmd_ready=1 again at T+5.
- Read: op 10 accepted at T, bus_din=0xA5 throughout.
  - rd_n=0 at T+2..T+3, oe=0 throughout.
  - rsp_valid=1 at T+4 only, rsp_rdata=0xA5 from T+4.
- Execute: op 11 accepted at T → excute=1 at T+1..T+4, cs_n=1 throughout, cmd_ready=1 at T+5.
- Back-to-back: addr 0x03 then data 0x7F with cmd_valid held high.
  - Exactly one cs_n=1 cycle between the two CS windows.
  - cd changes 1→0 only while cs_n=1.
- Reset abort: assert rst=0 during the second STROBE cycle of a read.
  - Next cycle all pins are at reset values, rsp_valid never pulses, rsp_rdata=0.
- Params SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, write data 0xC3 accepted at T.
  - cs_n=0 T+1..T+7, wr_n=0 T+3..T+5, cmd_ready=1 at T+8.
